// File: rtl/picoblaze_io_bank_if.sv
// Port bus between a pacoblaze3 core and its I/O bank.
// No storage or latency of its own; only groups the core-side signals.
// The core has no backpressure; the bank takes every strobe in the cycle it is presented.
interface picoblaze_io_bank_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/picoblaze_io_bank.sv
// I/O bank for pacoblaze3: output registers, input mux, sample FIFO, masked 3-source interrupt.
// Latency: in_port is registered one cycle after port_id; writes, pushes and interrupts land one cycle after their edge.
// No backpressure: a sample that finds storage full (and not popped) is dropped and flags overflow.
// Build option PICOBLAZE_IO_BANK_FIFO_EN: FIFO of FIFO_DEPTH bytes; undefined: single holding register.
module picoblaze_io_bank #(
  parameter int NUM_OUT    = 5,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  picoblaze_io_bank_if.slave    bus,
  input  logic                  sample_strobe,
  input  logic [7:0]            sample_data,
  input  logic [NUM_IN*8-1:0]   ext_in,
  output logic [NUM_OUT*8-1:0]  out_regs
);

  // Reject parameter values the decode and counters are not built for.
  if (NUM_OUT < 1 || NUM_OUT > 32) begin : g_chk_num_out
    $error("picoblaze_io_bank: NUM_OUT must be 1..32");
  end
  if (NUM_IN < 1 || NUM_IN > 32) begin : g_chk_num_in
    $error("picoblaze_io_bank: NUM_IN must be 1..32");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 128 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("picoblaze_io_bank: FIFO_DEPTH must be a power of two in 2..128");
  end

  localparam logic [7:0] ADDR_MASK   = 8'h40;
  localparam logic [7:0] ADDR_W1C    = 8'h41;
  localparam logic [7:0] ADDR_WMARK  = 8'h42;
  localparam logic [7:0] ADDR_STATUS = 8'h40;
  localparam logic [7:0] ADDR_COUNT  = 8'h41;
  localparam logic [7:0] ADDR_HEAD   = 8'h42;

  typedef enum logic {IDLE, REQ} irq_state_t;

  logic [NUM_OUT*8-1:0] out_regs_q, out_regs_d;
  logic [2:0]           irq_mask_q, irq_mask_d;
  logic [2:0]           pending_q, pending_d;
  logic [7:0]           in_port_q, in_port_d;
  irq_state_t           state_q;

  // Storage view shared by both storage flavours.
  logic       full, empty;
  logic [7:0] count8, head;
  logic       pop, push, overflow, wm_hit;
  logic [2:0] set_ev, w1c;
  logic       mask_wr, irq_qual;

  // Pop only when the head is really there; a push into a full store needs a pop in the same edge.
  always_comb begin
    pop      = bus.read_strobe && (bus.port_id == ADDR_HEAD) && !empty;
    push     = sample_strobe && (!full || pop);
    overflow = sample_strobe && full && !pop;
  end

`ifdef PICOBLAZE_IO_BANK_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    watermark_q, watermark_d;
  logic [7:0]    count8_nxt;

  // Pointer/count update; pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    watermark_d = (bus.write_strobe && bus.port_id == ADDR_WMARK) ? bus.out_port : watermark_q;
    full        = (count_q == CW'(FIFO_DEPTH));
    empty       = (count_q == '0);
    count8      = 8'(count_q);
    count8_nxt  = 8'(count_d);
    head        = empty ? 8'h00 : mem_q[rd_ptr_q];
    wm_hit      = (watermark_q != 8'h00) && (count8 < watermark_q) && (count8_nxt >= watermark_q);
  end

  // FIFO control state; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      watermark_q <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      watermark_q <= watermark_d;
    end
  end

  // Sample storage; entries are only read while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sample_data;
  end
`else
  logic       valid_q, valid_d;
  logic [7:0] hold_q, hold_d;

  // Single-byte holding register: a new sample replaces a byte being popped in the same edge.
  always_comb begin
    valid_d = push ? 1'b1 : (pop ? 1'b0 : valid_q);
    hold_d  = push ? sample_data : hold_q;
    full    = valid_q;
    empty   = !valid_q;
    count8  = {7'b0, valid_q};
    head    = valid_q ? hold_q : 8'h00;
    wm_hit  = 1'b0;
  end

  // Holding register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end
`endif

  // Fully decoded output register writes.
  always_comb begin
    out_regs_d = out_regs_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (bus.write_strobe && bus.port_id == 8'(k)) out_regs_d[8*k +: 8] = bus.out_port;
    end
  end

  // Mask, pending bits and the interrupt qualifier; a set event beats a clear on the same bit.
  always_comb begin
    mask_wr    = bus.write_strobe && (bus.port_id == ADDR_MASK);
    irq_mask_d = mask_wr ? bus.out_port[2:0] : irq_mask_q;
    w1c        = (bus.write_strobe && bus.port_id == ADDR_W1C) ? bus.out_port[2:0] : 3'b000;
    set_ev     = {overflow, wm_hit, sample_strobe};
    pending_d  = (pending_q & ~w1c) | set_ev;
    irq_qual   = (|(set_ev & irq_mask_q)) ||
                 (mask_wr && |(bus.out_port[2:0] & ~irq_mask_q & pending_q));
  end

  // Read mux, evaluated from the current port_id every cycle; unmapped reads give zero.
  always_comb begin
    in_port_d = 8'h00;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.port_id == 8'(k)) in_port_d = ext_in[8*k +: 8];
    end
    case (bus.port_id)
      ADDR_STATUS: in_port_d = {3'b000, full, empty, pending_q};
      ADDR_COUNT:  in_port_d = count8;
      ADDR_HEAD:   in_port_d = head;
      default:     ;
    endcase
  end

  // Register state for outputs, mask, pending and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_regs_q <= '0;
      irq_mask_q <= 3'b000;
      pending_q  <= 3'b000;
      in_port_q  <= 8'h00;
    end else begin
      out_regs_q <= out_regs_d;
      irq_mask_q <= irq_mask_d;
      pending_q  <= pending_d;
      in_port_q  <= in_port_d;
    end
  end

  // Interrupt request FSM; a qualifying event in the ack cycle keeps the request up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (irq_qual) state_q <= REQ;
        REQ:     if (bus.interrupt_ack && !irq_qual) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = (state_q == REQ);
  assign out_regs      = out_regs_q;

endmodule

// File: tb/tb_picoblaze_io_bank.sv
// Bench for picoblaze_io_bank: directed steps plus random traffic against a queue-based model.
module tb_picoblaze_io_bank;
  localparam int NUM_OUT    = 5;
  localparam int NUM_IN     = 4;
  localparam int FIFO_DEPTH = 16;
`ifdef PICOBLAZE_IO_BANK_FIFO_EN
  localparam int MDEPTH = FIFO_DEPTH;
  localparam bit WM_EN  = 1'b1;
`else
  localparam int MDEPTH = 1;
  localparam bit WM_EN  = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 sample_strobe;
  logic [7:0]           sample_data;
  logic [NUM_IN*8-1:0]  ext_in;
  logic [NUM_OUT*8-1:0] out_regs;

  picoblaze_io_bank_if bus();

  picoblaze_io_bank #(.NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus.slave),
    .sample_strobe (sample_strobe),
    .sample_data   (sample_data),
    .ext_in        (ext_in),
    .out_regs      (out_regs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_out [NUM_OUT];
  logic [2:0] m_mask, m_pend;
  logic [7:0] m_wm, m_rd;
  bit         m_irq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NUM_OUT; k++) m_out[k] = 8'h00;
    m_mask = 3'b000; m_pend = 3'b000; m_wm = 8'h00; m_rd = 8'h00; m_irq = 1'b0;
  endtask

  function automatic logic [7:0] model_read();
    int p = int'(bus.port_id);
    if (p < NUM_IN) return ext_in[8*p +: 8];
    if (p == 'h40) return {3'b000, mq.size() == MDEPTH, mq.size() == 0, m_pend};
    if (p == 'h41) return 8'(mq.size());
    if (p == 'h42) return (mq.size() > 0) ? mq[0] : 8'h00;
    return 8'h00;
  endfunction

  function automatic logic [NUM_OUT*8-1:0] model_outs();
    logic [NUM_OUT*8-1:0] v;
    for (int k = 0; k < NUM_OUT; k++) v[8*k +: 8] = m_out[k];
    return v;
  endfunction

  // Apply one clock edge to the model, advance the DUT, then compare.
  task automatic tick();
    logic [7:0] rd;
    logic [2:0] set, clr;
    int         old_n;
    bit         pop, ovf, qual, wr;
    rd    = model_read();
    old_n = mq.size();
    wr    = bus.write_strobe;
    pop   = bus.read_strobe && bus.port_id == 8'h42 && old_n > 0;
    ovf   = 1'b0;
    if (pop) void'(mq.pop_front());
    if (sample_strobe) begin
      if (mq.size() < MDEPTH) mq.push_back(sample_data);
      else ovf = 1'b1;
    end
    set[0] = sample_strobe;
    set[2] = ovf;
    set[1] = WM_EN && m_wm != 0 && old_n < int'(m_wm) && mq.size() >= int'(m_wm);
    qual = (|(set & m_mask)) ||
           (wr && bus.port_id == 8'h40 && |(bus.out_port[2:0] & ~m_mask & m_pend));
    clr = (wr && bus.port_id == 8'h41) ? bus.out_port[2:0] : 3'b000;
    m_pend = (m_pend & ~clr) | set;
    if (wr && bus.port_id == 8'h40) m_mask = bus.out_port[2:0];
    if (wr && bus.port_id == 8'h42 && WM_EN) m_wm = bus.out_port;
    if (wr && int'(bus.port_id) < NUM_OUT) m_out[int'(bus.port_id)] = bus.out_port;
    if (!m_irq) m_irq = qual;
    else if (bus.interrupt_ack) m_irq = qual;
    m_rd = rd;
    @(posedge clk); #1;
    check("in_port", 64'(bus.in_port), 64'(m_rd));
    check("interrupt", 64'(bus.interrupt), 64'(m_irq));
    check("out_regs", 64'(out_regs), 64'(model_outs()));
  endtask

  task automatic idle_inputs();
    bus.write_strobe = 1'b0; bus.read_strobe = 1'b0; bus.interrupt_ack = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic wr_port(input logic [7:0] a, input logic [7:0] d);
    bus.port_id = a; bus.out_port = d; bus.write_strobe = 1'b1;
    tick();
    bus.write_strobe = 1'b0;
  endtask

  task automatic rd_port(input logic [7:0] a);
    bus.port_id = a;
    tick();
  endtask

  // Two-cycle core INPUT of the FIFO head: address first, then the strobe.
  task automatic pop_head();
    bus.port_id = 8'h42; bus.read_strobe = 1'b0;
    tick();
    bus.read_strobe = 1'b1;
    tick();
    bus.read_strobe = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] d);
    sample_strobe = 1'b1; sample_data = d;
    tick();
    sample_strobe = 1'b0;
  endtask

  initial begin
    logic [7:0] ports [12];
    ports = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h40, 8'h41, 8'h42, 8'h45, 8'h90, 8'h1f};

    reset_n = 1'b0;
    bus.port_id = 8'h00; bus.out_port = 8'h00;
    idle_inputs();
    sample_data = 8'h00;
    for (int k = 0; k < NUM_IN; k++) ext_in[8*k +: 8] = 8'($urandom);
    ext_in[8*3 +: 8] = 8'h77;
    model_reset();
    #3;
    check("reset_in_port", 64'(bus.in_port), 64'h0);
    check("reset_interrupt", 64'(bus.interrupt), 64'h0);
    check("reset_out_regs", 64'(out_regs), 64'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Output register decode
    wr_port(8'h02, 8'hA5);
    wr_port(8'h45, 8'h3C);
    check("out2_a5", 64'(out_regs[23:16]), 64'hA5);
    check("out_others_zero", 64'(out_regs & ~(40'hFF << 16)), 64'h0);

    // Input channel and unmapped read
    rd_port(8'h03);
    check("ext_ch3", 64'(bus.in_port), 64'h77);
    rd_port(8'h90);
    check("unmapped_read", 64'(bus.in_port), 64'h0);

    // Watermark interrupt and drain
    wr_port(8'h42, 8'h04);
    wr_port(8'h40, 8'h02);
    for (int i = 1; i <= 4; i++) strobe(8'(i));
    rd_port(8'h41);
    for (int i = 0; i < 4; i++) pop_head();
    rd_port(8'h41);
    rd_port(8'h40);

    // Acknowledge, clear, then fill past capacity
    bus.interrupt_ack = 1'b1; rd_port(8'h00); bus.interrupt_ack = 1'b0;
    wr_port(8'h41, 8'h07);
    wr_port(8'h42, 8'h00);
    for (int i = 0; i <= MDEPTH; i++) strobe(8'($urandom));
    rd_port(8'h40);
    rd_port(8'h41);
    wr_port(8'h41, 8'h04);
    bus.port_id = 8'h42; tick();
    bus.read_strobe = 1'b1; sample_strobe = 1'b1; sample_data = 8'hEE;
    tick();
    bus.read_strobe = 1'b0; sample_strobe = 1'b0;
    rd_port(8'h40);
    rd_port(8'h41);

    // Ack collision keeps the request; a plain ack drops it
    wr_port(8'h40, 8'h01);
    strobe(8'h11);
    bus.interrupt_ack = 1'b1; sample_strobe = 1'b1; sample_data = 8'h22;
    tick();
    check("ack_with_event_stays", 64'(bus.interrupt), 64'h1);
    sample_strobe = 1'b0;
    tick();
    check("plain_ack_drops", 64'(bus.interrupt), 64'h0);
    bus.interrupt_ack = 1'b0;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      bus.port_id = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ports[$urandom_range(0, 11)];
      bus.write_strobe = ($urandom_range(0, 3) == 0);
      bus.read_strobe  = ($urandom_range(0, 2) == 0);
      bus.out_port = 8'($urandom);
      if (bus.port_id == 8'h42) bus.out_port = 8'($urandom_range(0, 8));
      sample_strobe = ($urandom_range(0, 2) == 0);
      sample_data = 8'($urandom);
      bus.interrupt_ack = m_irq && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) ext_in[8*$urandom_range(0, NUM_IN-1) +: 8] = 8'($urandom);
      tick();
    end
    idle_inputs();

    // Asynchronous reset mid-burst
    ext_in[7:0] = 8'h81;
    wr_port(8'h00, 8'h5A);
    wr_port(8'h40, 8'h01);
    sample_strobe = 1'b1; sample_data = 8'h33;
    bus.port_id = 8'h00;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("async_rst_in_port", 64'(bus.in_port), 64'h0);
    check("async_rst_interrupt", 64'(bus.interrupt), 64'h0);
    check("async_rst_out_regs", 64'(out_regs), 64'h0);
    model_reset();
    sample_strobe = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_port(8'h41);
    check("count_after_rst", 64'(bus.in_port), 64'h0);
    rd_port(8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/picoblaze_io_bank.md
# picoblaze_io_bank

Parametrised I/O and interrupt subsystem for a `pacoblaze3` core. It replaces the hand-written one-hot port decode and single-source interrupt flop used so far. It provides:
- N fully decoded output registers and M external input channels on a pipelined read mux.
- A sample FIFO fed by a periodic data strobe.
- A masked three-source interrupt controller with PicoBlaze `interrupt_ack` handshake.

It sits between the core's port bus and the board-level data sources and indicators.

## Interface
- `NUM_OUT`, default 5: number of 8-bit output registers, range 1–32.
- `NUM_IN`, default 4: number of 8-bit external input channels, range 1–32.
- `FIFO_DEPTH`, default 16: sample FIFO depth, power of two, range 2–128.

- `clk`  in  1  system clock; all logic rises on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `port_id`  in  8  core port address.
- `out_port`  in  8  core write data.
- `write_strobe`  in  1  core OUTPUT strobe.
- `read_strobe`  in  1  core INPUT strobe.
- `in_port`  out  8  registered read data to core.
- `interrupt`  out  1  interrupt request to core.
- `interrupt_ack`  in  1  core interrupt acknowledge.
- `sample_strobe`  in  1  one-cycle clock-enable pulse; `sample_data` valid.
- `sample_data`  in  8  sample byte.
- `ext_in`  in  NUM_IN*8  input channels; channel k is bits [8k+7:8k].
- `out_regs`  out  NUM_OUT*8  output registers; register k is bits [8k+7:8k].

## Operation
- Writes use full 8-bit compare, not one-hot. When `write_strobe` is high:
  - 0x00..NUM_OUT-1: write the selected `out_regs` register.
  - 0x40: write `irq_mask[2:0]`.
  - 0x41: write-1-to-clear `pending[2:0]`.
  - 0x42: write `watermark`.
  - Other addresses: no effect.
- Reads return data on `in_port`, registered every cycle from the current `port_id`:
  - 0x00..NUM_IN-1: the selected `ext_in` channel.
  - 0x40: status = {3'b0, full, empty, pending[2:0]}.
  - 0x41: FIFO count.
  - 0x42: FIFO head, or 0x00 if empty.
  - Unmapped addresses: 0x00, never X.
- FIFO pop: on a posedge with `read_strobe`, `port_id`=0x42 and FIFO non-empty. Read of an empty FIFO does not pop and has no side effects.
- FIFO push: on a posedge with `sample_strobe`.
  - Full with no simultaneous pop: byte dropped, count unchanged, `pending[2]` (overflow) set.
  - Full with a simultaneous pop: push accepted, no overflow.
  - Empty with a simultaneous push: push accepted, no pop.
- Pending sources:
  - `pending[0]`: set on every `sample_strobe`.
  - `pending[1]`: set when count crosses from < `watermark` to >= `watermark`. `watermark`=0 disables this source.
  - `pending[2]`: overflow.
  - If a set event and a W1C hit the same bit in one cycle, the set wins.
- Interrupt controller, two states:
  - IDLE → REQ when a pending bit is newly set while its mask bit is 1, or when a mask write enables an already-pending bit.
  - REQ → IDLE on `interrupt_ack`. If a qualifying event occurs in the ack cycle, the controller stays in REQ.
  - `interrupt` = (state == REQ).
  - Pending bits are not cleared by ack; software clears them via 0x41.
- Reset, asynchronous: all `out_regs`=0, `irq_mask`=0, `pending`=0, `watermark`=0, FIFO empty with count 0, `in_port`=0, state IDLE, `interrupt`=0. Reset asserted mid-operation discards FIFO contents immediately.

## Timing
- Output register: updated at the `write_strobe` edge; visible on `out_regs` the next cycle.
- `in_port` latency: one cycle from `port_id`. This matches the core's two-cycle INPUT; the head is captured before the pop edge.
- Sample: pushed at the `sample_strobe` edge. Count, pending bit and `interrupt` are all visible one cycle after the strobe.
- `interrupt` falls the cycle after `interrupt_ack`. Minimum re-assert is one cycle later.
- Back-to-back `sample_strobe` on consecutive cycles must be accepted.

## Configuration
- `PICOBLAZE_IO_BANK_FIFO_EN` defined: FIFO of `FIFO_DEPTH` as above.
- Undefined: a single-byte holding register replaces the FIFO.
  - Count is 0 or 1; full equals valid.
  - Overflow is set when a strobe arrives while valid and not popped.
  - `pending[1]` is never set.
  - `FIFO_DEPTH` is ignored.

## Test plan
- Reset then write 0xA5 to 0x02 and 0x3C to 0x45 → `out_regs[2]`=0xA5 next cycle; all other registers stay 0.
- `ext_in` channel 3=0x77; read 0x03 → `in_port`=0x77 one cycle after `port_id`. Read 0x90 → 0x00.
- Mask=0x02, watermark=4, four strobes with data 1,2,3,4 → `interrupt` rises one cycle after the 4th strobe. Reads of 0x42 return 1,2,3,4; count goes to 0.
- FIFO filled to 16, then a 17th strobe → overflow bit set, count 16, 17th byte lost. Strobe plus pop in the same cycle while full → no overflow.
- `interrupt` high, `interrupt_ack` with a simultaneous new enabled `sample_strobe` → `interrupt` stays high. A plain ack → `interrupt` low next cycle.
- Assert `reset_n` low mid-burst → outputs 0 immediately, with no clock edge required.
